// File: rtl/jesd204b_tx_link_seq.sv
`default_nettype none
// ============================================================================
// jesd204b_tx_link_seq : single-lane JESD204B TX link sequencer (CGS/ILAS/DATA)
// feeding the 8b/10b ROM; K-code error supervision when JESD_TX_KERR_CHECK_EN.
// Revision 1.0
// ============================================================================
module jesd204b_tx_link_seq #(
  parameter int F = 2,
  parameter int K = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_enable,
  input  logic                   i_sync_n,
  input  logic [111:0]           i_cfg,
  input  logic [7:0]             i_data,
  input  logic                   i_k_error,
  input  logic                   i_err_clr,
  output logic [7:0]             o_addr,
  output logic                   o_k,
  output logic                   o_rd_en,
  output logic                   o_data_ready,
  output logic [1:0]             o_state,
  output logic [$clog2(F*K)-1:0] o_lmfc,
  output logic                   o_k_err
);

  localparam int FK = F * K;
  localparam int LW = $clog2(FK);
  localparam logic [LW-1:0] C_LMFC_LAST = LW'(FK - 1);
  localparam logic [7:0] C_K28_0 = 8'h1C;
  localparam logic [7:0] C_K28_3 = 8'h7C;
  localparam logic [7:0] C_K28_4 = 8'h9C;
  localparam logic [7:0] C_K28_5 = 8'hBC;

  if (FK < 17 || FK > 1024) begin : g_fk_range_check
    $error("jesd204b_tx_link_seq: F*K must lie in 17..1024");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CGS  = 2'd1,
    ST_ILAS = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  state_t          r_state, w_state_next;
  logic [LW-1:0]   r_lmfc, w_lmfc_next, w_lmfc_inc;
  logic [1:0]      r_mf, w_mf_next;
  logic            r_go, w_go_next;
  logic            r_sync_meta, r_sync_s;
  logic [2:0]      r_lowcnt;
  logic            w_resync;
  logic [7:0]      r_addr, w_addr;
  logic            r_k, w_k;
  logic            r_rd_en, w_rd_en;
  logic [9:0]      w_j10;
  logic [3:0]      w_cfg_idx;

  // SYNC~ synchroniser; idle-high so reset looks like "no request"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_meta <= 1'b1;
      r_sync_s    <= 1'b1;
    end else begin
      r_sync_meta <= i_sync_n;
      r_sync_s    <= r_sync_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lowcnt <= 3'd0;
    end else if (r_sync_s) begin
      r_lowcnt <= 3'd0;
    end else if (r_lowcnt != 3'd4) begin
      r_lowcnt <= r_lowcnt + 3'd1;
    end
  end

  // fires only on the edge where the low run reaches its fourth sample
  assign w_resync   = !r_sync_s && (r_lowcnt == 3'd3);
  assign w_lmfc_inc = (r_lmfc == C_LMFC_LAST) ? '0 : r_lmfc + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_lmfc  <= '0;
      r_mf    <= 2'd0;
      r_go    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_lmfc  <= w_lmfc_next;
      r_mf    <= w_mf_next;
      r_go    <= w_go_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_lmfc_next  = w_lmfc_inc;
    w_mf_next    = r_mf;
    w_go_next    = r_go;
    case (r_state)
      ST_IDLE: begin
        w_lmfc_next = '0;
        w_mf_next   = 2'd0;
        w_go_next   = 1'b0;
        if (i_enable) w_state_next = ST_CGS;
      end
      ST_CGS: begin
        w_go_next = r_sync_s;
        if (r_go && (w_lmfc_inc == '0)) begin
          w_state_next = ST_ILAS;
          w_mf_next    = 2'd0;
        end
      end
      ST_ILAS: begin
        if (w_lmfc_inc == '0) begin
          if (r_mf == 2'd3) w_state_next = ST_DATA;
          else              w_mf_next    = r_mf + 2'd1;
        end
      end
      default: ;
    endcase
    if ((r_state != ST_IDLE) && w_resync) begin
      w_state_next = ST_CGS;
      w_go_next    = 1'b0;
    end
    if (!i_enable) begin
      w_state_next = ST_IDLE;
      w_lmfc_next  = '0;
      w_go_next    = 1'b0;
    end
  end

  // octet selection is driven by the next state so o_addr and o_lmfc stay aligned
  assign w_j10     = 10'(w_lmfc_next);
  assign w_cfg_idx = 4'(w_j10 - 10'd2);

  always_comb begin
    w_addr  = 8'h00;
    w_k     = 1'b0;
    w_rd_en = 1'b0;
    case (w_state_next)
      ST_CGS: begin
        w_addr  = C_K28_5;
        w_k     = 1'b1;
        w_rd_en = 1'b1;
      end
      ST_ILAS: begin
        w_rd_en = 1'b1;
        if (w_lmfc_next == '0) begin
          w_addr = C_K28_0;
          w_k    = 1'b1;
        end else if (w_lmfc_next == C_LMFC_LAST) begin
          w_addr = C_K28_3;
          w_k    = 1'b1;
        end else if ((w_mf_next == 2'd1) && (w_j10 == 10'd1)) begin
          w_addr = C_K28_4;
          w_k    = 1'b1;
        end else if ((w_mf_next == 2'd1) && (w_j10 <= 10'd15)) begin
          w_addr = i_cfg[{w_cfg_idx, 3'b000} +: 8];
        end else begin
          w_addr = w_j10[7:0];
        end
      end
      ST_DATA: begin
        w_addr  = i_data;
        w_rd_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= 8'h00;
      r_k     <= 1'b0;
      r_rd_en <= 1'b0;
    end else begin
      r_addr  <= w_addr;
      r_k     <= w_k;
      r_rd_en <= w_rd_en;
    end
  end

  assign o_addr  = r_addr;
  assign o_k     = r_k;
  assign o_rd_en = r_rd_en;
  assign o_state = r_state;
  assign o_lmfc  = r_lmfc;

  // the last ILAS octet cycle already pulls the first user octet so DATA starts at lmfc 0
  assign o_data_ready = (r_state == ST_DATA) ||
                        ((r_state == ST_ILAS) && (r_mf == 2'd3) && (r_lmfc == C_LMFC_LAST));

`ifdef JESD_TX_KERR_CHECK_EN
  logic r_kq;
  logic r_k_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kq    <= 1'b0;
      r_k_err <= 1'b0;
    end else begin
      r_kq <= r_rd_en & r_k;
      if (r_kq && i_k_error) r_k_err <= 1'b1;
      else if (i_err_clr)    r_k_err <= 1'b0;
    end
  end

  assign o_k_err = r_k_err;
`else
  logic w_unused_kerr;
  assign w_unused_kerr = i_k_error ^ i_err_clr;
  assign o_k_err       = 1'b0;
`endif

endmodule
`default_nettype wire
